// File: rtl/wb_port_arbiter_pkg.sv
// Shared types for the writeback port arbiter.
//   id_t        : instruction id carried with every writeback
//   wb_packet_t : {id, valid, data} as driven onto the register-file port
//   wb_src_t    : index of the source that owns the current writeback
//   multi_hot() : true when two or more bits of a request vector are set
package wb_port_arbiter_pkg;

  localparam int XLEN                = 32;
  localparam int ID_WIDTH            = 4;
  localparam int DEFAULT_NUM_SOURCES = 4;

  typedef logic [ID_WIDTH-1:0] id_t;

  typedef struct packed {
    id_t             id;
    logic            valid;
    logic [XLEN-1:0] data;
  } wb_packet_t;

  typedef logic [$clog2(DEFAULT_NUM_SOURCES)-1:0] wb_src_t;

  // v & (v-1) clears the lowest set bit; anything left means >= 2 bits set.
  // Request vectors up to 32 sources are supported.
  function automatic logic multi_hot(input logic [31:0] v);
    return (v & (v - 32'd1)) != 32'd0;
  endfunction

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Bundle between the writeback units and the arbiter.
//   master : writeback units side (drives requests, sees acks and the port)
//   slave  : arbiter side
// Handshake: a source raises src_valid[i] with src_id[i]/src_data[i] and holds
// all three stable until it sees src_ack[i]=1 in the same cycle. The request
// is consumed on that clock edge; in the next cycle the source either drops
// src_valid[i] or presents its next result. At most one ack bit is ever set.
interface wb_port_arbiter_if
  import wb_port_arbiter_pkg::*;
#(
  parameter int NUM_SOURCES = DEFAULT_NUM_SOURCES,
  parameter int DATA_WIDTH  = XLEN
);
  logic                           writeback_suppress;
  logic [NUM_SOURCES-1:0]         src_valid;
  id_t                            src_id   [NUM_SOURCES];
  logic [DATA_WIDTH-1:0]          src_data [NUM_SOURCES];
  logic [NUM_SOURCES-1:0]         src_ack;
  wb_packet_t                     wb;
  logic [$clog2(NUM_SOURCES)-1:0] wb_src;
  logic                           conflict_stall;

  modport master (
    output writeback_suppress, src_valid, src_id, src_data,
    input  src_ack, wb, wb_src, conflict_stall
  );

  modport slave (
    input  writeback_suppress, src_valid, src_id, src_data,
    output src_ack, wb, wb_src, conflict_stall
  );
endinterface

// File: rtl/wb_port_arbiter_rr_priority_encoder.sv
// Rotated-priority encoder, purely combinational.
//   req_i : request vector
//   ptr_i : index with highest priority; priority falls off ptr, ptr+1, ... mod N
//   gnt_o : one-hot winner (zero when no request)
//   idx_o : binary index of the winner (zero when no request)
//   any_o : at least one request present
module rr_priority_encoder #(
  parameter  int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic [N-1:0] gnt_o,
  output logic [W-1:0] idx_o,
  output logic         any_o
);

  always_comb begin
    logic [W-1:0] j;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    j     = '0;
    for (int k = 0; k < N; k++) begin
      j = W'((int'(ptr_i) + k) % N);
      if (!any_o && req_i[j]) begin
        any_o    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = j;
      end
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares one register-file writeback port among NUM_SOURCES writeback units.
// One request per cycle is picked round-robin, acked combinationally and
// registered onto the port, so it appears on wb exactly one cycle later.
//   clk, rst  : core clock, asynchronous active-high reset
//   bus       : slave side of wb_port_arbiter_if (requests, acks, wb port,
//               wb_src, conflict_stall, writeback_suppress)
//   rr_ptr_o  : current round-robin pointer (debug visibility)
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int NUM_SOURCES = DEFAULT_NUM_SOURCES,
  parameter int DATA_WIDTH  = XLEN
) (
  input  logic                           clk,
  input  logic                           rst,
  wb_port_arbiter_if.slave               bus,
  output logic [$clog2(NUM_SOURCES)-1:0] rr_ptr_o
);

  localparam int SRC_W = $clog2(NUM_SOURCES);

  logic [SRC_W-1:0]       rr_ptr_q, rr_ptr_d;
  wb_packet_t             wb_q, wb_d;
  logic [SRC_W-1:0]       wb_src_q, wb_src_d;
  logic [NUM_SOURCES-1:0] pe_gnt;
  logic [SRC_W-1:0]       pe_idx;
  logic                   pe_any;
  logic                   grant;

  rr_priority_encoder #(.N(NUM_SOURCES)) u_pe (
    .req_i (bus.src_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (pe_gnt),
    .idx_o (pe_idx),
    .any_o (pe_any)
  );

  // rst gates the ack so no source believes it was consumed while the
  // output register is being cleared.
  assign grant          = pe_any & ~bus.writeback_suppress & ~rst;
  assign bus.src_ack    = grant ? pe_gnt : '0;
  assign bus.conflict_stall = multi_hot(32'(bus.src_valid)) & ~bus.writeback_suppress;

  // On idle cycles only valid drops; id/data/src keep their last value.
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    wb_d        = wb_q;
    wb_d.valid  = 1'b0;
    wb_src_d    = wb_src_q;
    if (grant) begin
      rr_ptr_d   = (pe_idx == SRC_W'(NUM_SOURCES - 1)) ? '0 : pe_idx + 1'b1;
      wb_d.id    = bus.src_id[pe_idx];
      wb_d.valid = 1'b1;
      wb_d.data  = bus.src_data[pe_idx];
      wb_src_d   = pe_idx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q <= '0;
      wb_q     <= '0;
      wb_src_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      wb_q     <= wb_d;
      wb_src_q <= wb_src_d;
    end
  end

  assign bus.wb     = wb_q;
  assign bus.wb_src = wb_src_q;
  assign rr_ptr_o   = rr_ptr_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;
  import wb_port_arbiter_pkg::*;

  localparam int NS = 4;
  localparam int DW = 32;
  localparam int EW = ID_WIDTH + 1 + XLEN + 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  wb_port_arbiter_if #(.NUM_SOURCES(NS), .DATA_WIDTH(DW)) bus ();
  wb_src_t rr_ptr;

  wb_port_arbiter #(.NUM_SOURCES(NS), .DATA_WIDTH(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .rr_ptr_o (rr_ptr)
  );

  // ---------------- scoreboard state ----------------
  int            total = 0;
  int            bad   = 0;
  logic [EW-1:0] exp_q[$];

  logic [NS-1:0] pend     = '0;
  logic [NS-1:0] refill   = '0;
  logic [NS-1:0] last_ack = '0;
  id_t           m_id   [NS];
  logic [DW-1:0] m_data [NS];
  int            t_req  [NS];
  int            model_ptr = 0;
  int            cyc       = 0;
  int            next_id   = 0;
  int            max_wait  = 0;
  int            issued    = 0;
  int            written   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic new_packet(input int i, input int t);
    pend[i]   = 1'b1;
    m_id[i]   = id_t'(next_id);
    next_id++;
    m_data[i] = $urandom;
    t_req[i]  = t;
    issued++;
  endtask

  task automatic apply_inputs(input logic supp);
    bus.writeback_suppress = supp;
    bus.src_valid          = pend;
    for (int i = 0; i < NS; i++) begin
      bus.src_id[i]   = m_id[i];
      bus.src_data[i] = m_data[i];
    end
  endtask

  // One clock cycle, entered and left at posedge+1.
  task automatic step(input logic supp);
    logic [NS-1:0] exp_ack;
    logic [EW-1:0] exp_pkt;
    int            g;
    int            w;
    apply_inputs(supp);
    #3;
    exp_ack = '0;
    g       = -1;
    if (!supp) begin
      for (int k = 0; k < NS; k++) begin
        if (g < 0 && pend[(model_ptr + k) % NS]) g = (model_ptr + k) % NS;
      end
    end
    if (g >= 0) exp_ack[g] = 1'b1;
    last_ack = bus.src_ack;
    check("ack", 64'(bus.src_ack), 64'(exp_ack));
    check("conflict", 64'(bus.conflict_stall), 64'(!supp && ($countones(pend) >= 2)));
    check("rr_ptr", 64'(rr_ptr), 64'(model_ptr));
    if (g >= 0) begin
      exp_q.push_back({m_id[g], 1'b1, m_data[g], 2'(g)});
      model_ptr = (g + 1) % NS;
      w = cyc - t_req[g] + 1;
      if (w > max_wait) max_wait = w;
      if (refill[g]) new_packet(g, cyc + 1);
      else pend[g] = 1'b0;
    end
    @(posedge clk);
    #1;
    if (g >= 0) begin
      if (exp_q.size() == 0) begin
        check("sb_empty", 64'(1), 64'(0));
      end else begin
        exp_pkt = exp_q.pop_front();
        check("wb", 64'({bus.wb, bus.wb_src}), 64'(exp_pkt));
        written++;
      end
    end else begin
      check("wb_valid_idle", 64'(bus.wb.valid), 64'(0));
    end
    cyc++;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_ack"}, 64'(bus.src_ack), 64'(0));
    check({tag, "_wb"}, 64'({bus.wb, bus.wb_src}), 64'(0));
    check({tag, "_ptr"}, 64'(rr_ptr), 64'(0));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < NS; i++) begin
      m_id[i]   = '0;
      m_data[i] = '0;
      t_req[i]  = 0;
    end
    apply_inputs(1'b0);
    #1 rst = 1'b1;
    #2 check_reset_state("init");
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    // single request from source 2
    new_packet(2, cyc);
    m_id[2]   = id_t'(5);
    m_data[2] = 32'hDEADBEEF;
    step(1'b0);
    check("single_ack", 64'(last_ack), 64'(4'b0100));
    check("single_wb", 64'({bus.wb, bus.wb_src}), 64'({4'd5, 1'b1, 32'hDEADBEEF, 2'd2}));
    step(1'b0);
    check("hold_data", 64'(bus.wb.data), 64'(32'hDEADBEEF));
    check("hold_src", 64'(bus.wb_src), 64'(2));

    // wrap: pointer sits at 3, sources 0 and 3 request
    check("wrap_ptr", 64'(rr_ptr), 64'(3));
    new_packet(0, cyc);
    new_packet(3, cyc);
    step(1'b0);
    check("wrap_ack0", 64'(last_ack), 64'(4'b1000));
    step(1'b0);
    check("wrap_ack1", 64'(last_ack), 64'(4'b0001));

    // mid-stream reset with every source requesting
    refill = '1;
    for (int i = 0; i < NS; i++) if (!pend[i]) new_packet(i, cyc);
    step(1'b0);
    apply_inputs(1'b0);
    rst = 1'b1;
    #3 check_reset_state("midrst");
    check("midrst_valid", 64'(bus.src_valid), 64'(4'b1111));
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    model_ptr = 0;

    // round robin with all sources continuously valid
    for (int k = 0; k < 8; k++) begin
      step(1'b0);
      check("rr_order", 64'(last_ack), 64'(4'b0001 << (k % NS)));
    end

    // one source always valid: granted every cycle
    pend   = '0;
    refill = 4'b1000;
    new_packet(3, cyc);
    for (int k = 0; k < 4; k++) begin
      step(1'b0);
      check("b2b_ack", 64'(last_ack), 64'(4'b1000));
    end

    // writeback suppress holds off the request without consuming it
    pend   = '0;
    refill = '0;
    new_packet(1, cyc);
    step(1'b1);
    check("supp_ack", 64'(last_ack), 64'(0));
    step(1'b0);
    check("supp_release", 64'(last_ack), 64'(4'b0010));

    // random traffic
    max_wait = 0;
    issued   = 0;
    written  = 0;
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < NS; i++) begin
        if (!pend[i] && $urandom_range(0, 2) != 0) new_packet(i, cyc);
      end
      step(1'b0);
    end
    for (int k = 0; k < 2 * NS && pend != '0; k++) step(1'b0);
    step(1'b0);
    check("drain", 64'(pend), 64'(0));
    check("sb_left", 64'(exp_q.size()), 64'(0));
    check("exactly_once", 64'(written), 64'(issued));
    check("max_wait_ok", 64'(max_wait <= NS), 64'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
